myhardware_led_driver: RTL and testbench

// - Consumes the 10-bit LED pattern from the LEDS PIO out_port and drives the physical LED pins.
// - Applies a global brightness level by PWM and optionally fades each LED between off and on.
// - Sits between the PIO out_port and the top-level LEDR pins.
// - The brightness value comes from a second PIO or a constant tie-off.

---
 rtl/myhardware_led_driver_pkg.sv | 31 +++
 rtl/myhardware_led_driver_if.sv | 29 ++
 rtl/myhardware_led_channel.sv | 83 ++++++++
 rtl/myhardware_led_driver.sv | 99 +++++++++
 tb/tb_myhardware_led_driver.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/myhardware_led_driver_pkg.sv
// Shared definitions for the LED PWM driver.
// Holds the default geometry (channel count, brightness width, prescale),
// the fade step direction type and a helper that picks a step direction.
package myhardware_led_driver_pkg;

    localparam int unsigned DEF_NUM_LEDS = 10;
    localparam int unsigned DEF_PWM_BITS = 4;
    localparam int unsigned DEF_PRESCALE = 1000;
    localparam bit          DEF_FADE_EN  = 1'b1;

    // Direction a fading level moves on a frame boundary.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

    // Choose the single-step direction from the level/target relation.
    function automatic step_e step_dir(input logic below, input logic above);
        step_e dir;
        if (below) begin
            dir = STEP_UP;
        end else if (above) begin
            dir = STEP_DOWN;
        end else begin
            dir = STEP_HOLD;
        end
        return dir;
    endfunction

endpackage

// File: rtl/myhardware_led_driver_if.sv
// LED driver bus: PIO-side pattern/brightness inputs and the LED-side
// drive/status outputs.
//   pattern_in  LED on/off pattern          (master -> slave)
//   bright_in   global brightness target    (master -> slave)
//   led_out     PWM drive to the LED pins   (slave -> master)
//   busy        some level still fading     (slave -> master)
//   frame_tick  one-cycle PWM frame pulse   (slave -> master)
interface myhardware_led_driver_if
    import myhardware_led_driver_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
    parameter int unsigned PWM_BITS = DEF_PWM_BITS
);
    logic [NUM_LEDS-1:0] pattern_in;
    logic [PWM_BITS-1:0] bright_in;
    logic [NUM_LEDS-1:0] led_out;
    logic                busy;
    logic                frame_tick;

    modport master (
        output pattern_in, bright_in,
        input  led_out, busy, frame_tick
    );

    modport slave (
        input  pattern_in, bright_in,
        output led_out, busy, frame_tick
    );
endinterface

// File: rtl/myhardware_led_channel.sv
// One LED channel: holds the channel level, steps it toward the target
// (or jumps when fading is disabled) and compares it with the shared PWM
// counter to drive the registered LED output.
//   clk, reset    clock and synchronous active-high reset
//   on_i          this channel's registered pattern bit
//   bright_i      registered global brightness
//   frame_wrap_i  high on the cycle the PWM frame wraps
//   pwm_cnt_i     shared PWM counter
//   led_o         registered LED drive
//   busy_o        level differs from target (registered in the top)
module myhardware_led_channel
    import myhardware_led_driver_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter bit          FADE_EN  = DEF_FADE_EN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                on_i,
    input  logic [PWM_BITS-1:0] bright_i,
    input  logic                frame_wrap_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o,
    output logic                busy_o
);

    localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);

    logic [PWM_BITS-1:0] target_s;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic                led_q;
    step_e               step_s;

    // Target brightness for this channel.
    always_comb begin
        target_s = LVL_ZERO;
        if (on_i) begin
            target_s = bright_i;
        end else begin
            target_s = LVL_ZERO;
        end
    end

    // Step direction; only moving toward the target keeps the level in range.
    always_comb begin
        step_s = step_dir(level_q < target_s, level_q > target_s);
    end

    // Next level: jump when fading is off, else one step per frame wrap.
    always_comb begin
        level_d = level_q;
        if (FADE_EN == 1'b0) begin
            level_d = target_s;
        end else if (frame_wrap_i) begin
            case (step_s)
                STEP_UP:   level_d = level_q + LVL_ONE;
                STEP_DOWN: level_d = level_q - LVL_ONE;
                STEP_HOLD: level_d = level_q;
                default:   level_d = level_q;
            endcase
        end else begin
            level_d = level_q;
        end
    end

    // Level register and PWM compare flop; all-ones level is always on
    // because the counter never reaches all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= LVL_ZERO;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= (pwm_cnt_i < level_q);
        end
    end

    assign led_o  = led_q;
    assign busy_o = (level_q != target_s);

endmodule

// File: rtl/myhardware_led_driver.sv
// LED PWM driver top: registers the PIO pattern and brightness, runs the
// prescaler and PWM frame counter, and fans out to one channel per LED.
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    slave side of the LED driver interface
//          (pattern_in, bright_in in; led_out, busy, frame_tick out)
module myhardware_led_driver
    import myhardware_led_driver_pkg::*;
#(
    parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter int unsigned PRESCALE = DEF_PRESCALE,
    parameter bit          FADE_EN  = DEF_FADE_EN
) (
    input  logic                    clk,
    input  logic                    reset,
    myhardware_led_driver_if.slave  bus
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    logic [PS_W-1:0]     presc_q;
    logic [PS_W-1:0]     presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [NUM_LEDS-1:0] pattern_q;
    logic [PWM_BITS-1:0] bright_q;
    logic                frame_tick_q;
    logic                busy_q;
    logic                tick_s;
    logic                frame_wrap_s;
    logic [NUM_LEDS-1:0] led_vec_s;
    logic [NUM_LEDS-1:0] busy_vec_s;

    assign tick_s       = (presc_q == PS_LAST);
    assign frame_wrap_s = tick_s && (pwm_cnt_q == PWM_MAX);

    // Prescaler and PWM counter next state; the counter stops one short of
    // all-ones so a full-scale level stays on for the whole frame.
    always_comb begin
        presc_d   = presc_q;
        pwm_cnt_d = pwm_cnt_q;
        if (tick_s) begin
            presc_d = {PS_W{1'b0}};
            if (pwm_cnt_q == PWM_MAX) begin
                pwm_cnt_d = {PWM_BITS{1'b0}};
            end else begin
                pwm_cnt_d = pwm_cnt_q + PWM_ONE;
            end
        end else begin
            presc_d   = presc_q + PS_ONE;
            pwm_cnt_d = pwm_cnt_q;
        end
    end

    // Timebase, input capture and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= {PS_W{1'b0}};
            pwm_cnt_q    <= {PWM_BITS{1'b0}};
            pattern_q    <= {NUM_LEDS{1'b0}};
            bright_q     <= {PWM_BITS{1'b0}};
            frame_tick_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pattern_q    <= bus.pattern_in;
            bright_q     <= bus.bright_in;
            frame_tick_q <= frame_wrap_s;
            busy_q       <= |busy_vec_s;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        myhardware_led_channel #(
            .PWM_BITS (PWM_BITS),
            .FADE_EN  (FADE_EN)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .on_i         (pattern_q[gi]),
            .bright_i     (bright_q),
            .frame_wrap_i (frame_wrap_s),
            .pwm_cnt_i    (pwm_cnt_q),
            .led_o        (led_vec_s[gi]),
            .busy_o       (busy_vec_s[gi])
        );
    end

    assign bus.led_out    = led_vec_s;
    assign bus.busy       = busy_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_myhardware_led_driver.sv
// Bench for the LED PWM driver: one instance without fading, one with.
// A reference model derives expected outputs from elapsed cycles since
// reset and per-channel levels; a monitor compares every cycle.
module tb_myhardware_led_driver;
    localparam int P     = 2;
    localparam int NL    = 10;
    localparam int FRAME = 15 * P;

    typedef struct packed {
        logic [NL-1:0] led;
        logic          busy;
        logic          ft;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NL-1:0] pat_s = 10'h3FF;
    logic [3:0]    bri_s = 4'd15;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    myhardware_led_driver_if #(.NUM_LEDS(NL), .PWM_BITS(4)) if0 ();
    myhardware_led_driver_if #(.NUM_LEDS(NL), .PWM_BITS(4)) if1 ();

    assign if0.pattern_in = pat_s;
    assign if0.bright_in  = bri_s;
    assign if1.pattern_in = pat_s;
    assign if1.bright_in  = bri_s;

    myhardware_led_driver #(.NUM_LEDS(NL), .PWM_BITS(4), .PRESCALE(P), .FADE_EN(1'b0))
        dut0 (.clk(clk), .reset(rst), .bus(if0));
    myhardware_led_driver #(.NUM_LEDS(NL), .PWM_BITS(4), .PRESCALE(P), .FADE_EN(1'b1))
        dut1 (.clk(clk), .reset(rst), .bus(if1));

    // Reference model: PWM position from cycles since reset, levels as integers.
    initial begin : model
        int            k;
        int            lvl[2][NL];
        logic [NL-1:0] seen_pat;
        int            seen_bri;
        k = 0;
        seen_pat = '0;
        seen_bri = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NL; i++) lvl[f][i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                k = 0;
                seen_pat = '0;
                seen_bri = 0;
                for (int f = 0; f < 2; f++)
                    for (int i = 0; i < NL; i++) lvl[f][i] = 0;
                q0.push_back('0);
                q1.push_back('0);
            end else begin
                int pwm;
                bit wrap;
                pwm  = (k / P) % 15;
                wrap = ((k + 1) % FRAME) == 0;
                for (int f = 0; f < 2; f++) begin
                    exp_t e;
                    e = '0;
                    e.ft = wrap;
                    for (int i = 0; i < NL; i++) begin
                        int tgt;
                        tgt = seen_pat[i] ? seen_bri : 0;
                        e.led[i] = (pwm < lvl[f][i]);
                        if (lvl[f][i] != tgt) e.busy = 1'b1;
                        if (f == 0) lvl[f][i] = tgt;
                        else if (wrap && lvl[f][i] < tgt) lvl[f][i] = lvl[f][i] + 1;
                        else if (wrap && lvl[f][i] > tgt) lvl[f][i] = lvl[f][i] - 1;
                    end
                    if (f == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
                seen_pat = pat_s;
                seen_bri = int'(bri_s);
                k++;
            end
        end
    end

    task automatic cmp_out(input int idx, input exp_t e, input exp_t got);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL dut%0d_outputs t=%0t: got led=%h busy=%b ft=%b, expected led=%h busy=%b ft=%b",
                     idx, $time, got.led, got.busy, got.ft, e.led, e.busy, e.ft);
        end
    endtask

    // Monitor: one expected entry per clock for each instance.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (q0.size() > 0) cmp_out(0, q0.pop_front(), {if0.led_out, if0.busy, if0.frame_tick});
            if (q1.size() > 0) cmp_out(1, q1.pop_front(), {if1.led_out, if1.busy, if1.frame_tick});
        end
    end

    task automatic directed(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int cnt;
        int bad;
        // Reset held with all LEDs requested at full brightness.
        rst = 1'b1; pat_s = 10'h3FF; bri_s = 4'd15;
        cyc(3);
        rst = 1'b0;
        // Single LED, full then half-ish brightness (no fading instance).
        pat_s = 10'h001; bri_s = 4'd15;
        cyc(60);
        bri_s = 4'd8;
        cyc(4);
        cnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            cnt += int'(if0.led_out[0]);
        end
        directed("duty_level8_high_cycles", cnt, 16);
        // Ramp LED 9 up to 4 from zero.
        pat_s = 10'h000;
        cyc(16 * FRAME);
        pat_s = 10'h200; bri_s = 4'd4;
        cyc(6 * FRAME);
        directed("fade_up_busy_clear", int'(if1.busy), 0);
        // Reverse mid-ramp at level 2.
        pat_s = 10'h000;
        cyc(5 * FRAME);
        pat_s = 10'h200;
        cyc(2 * FRAME + 10);
        pat_s = 10'h000;
        cyc(4 * FRAME);
        directed("fade_down_busy_clear", int'(if1.busy), 0);
        // Reset mid-fade at level 6.
        pat_s = 10'h3FF; bri_s = 4'd15;
        cyc(6 * FRAME + 5);
        rst = 1'b1;
        cyc(1);
        directed("reset_mid_fade_led", int'(if1.led_out), 0);
        directed("reset_mid_fade_busy", int'(if1.busy), 0);
        rst = 1'b0;
        cyc(3 * FRAME);
        // Zero brightness with every LED enabled.
        bri_s = 4'd0;
        cyc(4);
        bad = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (if0.led_out != 10'h000 || if0.busy != 1'b0) bad++;
        end
        directed("bright0_dark_cycles", bad, 0);
        cyc(4 * FRAME);
        // Full brightness: fading instance ends constantly on.
        bri_s = 4'd15;
        cyc(16 * FRAME + 4);
        bad = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (if1.led_out != 10'h3FF) bad++;
        end
        directed("full_on_not_lit_cycles", bad, 0);
        // Random patterns, brightness and occasional resets.
        repeat (60) begin
            rst = ($urandom_range(0, 19) == 0);
            pat_s = 10'($urandom);
            bri_s = 4'($urandom);
            cyc($urandom_range(1, 80));
        end
        rst = 1'b0;
        cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
